// File: rtl/fft_pkg.sv
// fft_pkg: widths, FSM encoding and arithmetic helpers shared by the eight-point FFT/IFFT pair.
package fft_pkg;

  localparam int FFT_W  = 16;
  localparam int FFT_GW = FFT_W + 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S2    = 3'd2,
    SCALE = 3'd3,
    DONE  = 3'd4
  } fft_state_e;

  // Helpers work on 32-bit values; callers size-cast the result to their width.
  function automatic logic signed [31:0] sm2tc(input logic [31:0] v, input int w);
    logic [31:0] mag;
    mag = v & ((32'd1 << (w - 1)) - 32'd1);
    if (((v >> (w - 1)) & 32'd1) != 32'd0) sm2tc = -$signed(mag);
    else sm2tc = $signed(mag);
  endfunction

  // A zero magnitude always gets sign 0, so negative zero never appears.
  function automatic logic [31:0] tc2sm(input logic signed [31:0] v, input int w);
    logic [31:0] mag;
    mag = (v < 0) ? -v : v;
    tc2sm = (v < 0) ? (mag | (32'd1 << (w - 1))) : mag;
  endfunction

  // x * 0.70703125 by shift-add.
  function automatic logic signed [31:0] mul_c707(input logic signed [31:0] x);
    mul_c707 = (x >>> 1) + (x >>> 2) - (x >>> 4) + (x >>> 5)
             - (x >>> 6) + (x >>> 7) - (x >>> 8);
  endfunction

  // Real part of W8^-n * (r + j i).
  function automatic logic signed [31:0] tw_re(input logic signed [31:0] r,
                                               input logic signed [31:0] i,
                                               input int n);
    case (n)
      0:       tw_re = r;
      1:       tw_re = mul_c707(r - i);
      2:       tw_re = -i;
      default: tw_re = mul_c707(-r - i);
    endcase
  endfunction

  // Imaginary part of W8^-n * (r + j i).
  function automatic logic signed [31:0] tw_im(input logic signed [31:0] r,
                                               input logic signed [31:0] i,
                                               input int n);
    case (n)
      0:       tw_im = i;
      1:       tw_im = mul_c707(r + i);
      2:       tw_im = r;
      default: tw_im = mul_c707(r - i);
    endcase
  endfunction

endpackage

// File: rtl/idft4_core.sv
// idft4_core: combinational 4-point inverse DFT (+j kernel, no scaling) on signed operands.
module idft4_core
  import fft_pkg::*;
#(
  parameter int GW = FFT_GW
) (
  input  logic signed [GW-1:0] a_re_i [4],
  input  logic signed [GW-1:0] a_im_i [4],
  output logic signed [GW-1:0] y_re_o [4],
  output logic signed [GW-1:0] y_im_o [4]
);

  // j*(r + j i) = -i + j r, so the k=1/k=3 terms swap components.
  assign y_re_o[0] = a_re_i[0] + a_re_i[1] + a_re_i[2] + a_re_i[3];
  assign y_im_o[0] = a_im_i[0] + a_im_i[1] + a_im_i[2] + a_im_i[3];
  assign y_re_o[1] = a_re_i[0] - a_im_i[1] - a_re_i[2] + a_im_i[3];
  assign y_im_o[1] = a_im_i[0] + a_re_i[1] - a_im_i[2] - a_re_i[3];
  assign y_re_o[2] = a_re_i[0] - a_re_i[1] + a_re_i[2] - a_re_i[3];
  assign y_im_o[2] = a_im_i[0] - a_im_i[1] + a_im_i[2] - a_im_i[3];
  assign y_re_o[3] = a_re_i[0] + a_im_i[1] - a_re_i[2] - a_im_i[3];
  assign y_im_o[3] = a_im_i[0] - a_re_i[1] - a_im_i[2] + a_re_i[3];

endmodule

// File: rtl/eight_point_ifft.sv
// eight_point_ifft: 8-point inverse FFT, sign-magnitude in/out, output scaled by 1/8.
// Build option IFFT_ROUND_EN: round half toward +inf in the final divide by 8.
module eight_point_ifft
  import fft_pkg::*;
#(
  parameter int W  = FFT_W,
  parameter int GW = W + 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         write,
  input  logic         start,
  input  logic [W-1:0] in0_real, in1_real, in2_real, in3_real,
  input  logic [W-1:0] in4_real, in5_real, in6_real, in7_real,
  input  logic [W-1:0] in0_imag, in1_imag, in2_imag, in3_imag,
  input  logic [W-1:0] in4_imag, in5_imag, in6_imag, in7_imag,
  output logic [W-1:0] out0_real, out1_real, out2_real, out3_real,
  output logic [W-1:0] out4_real, out5_real, out6_real, out7_real,
  output logic [W-1:0] out0_imag, out1_imag, out2_imag, out3_imag,
  output logic [W-1:0] out4_imag, out5_imag, out6_imag, out7_imag,
  output logic         ready,
  output logic         busy,
  output logic [2:0]   dbg_state
);

  // Handshake: write (IDLE/DONE only, wins over start) loads inputs and returns to IDLE;
  // start (IDLE/DONE) launches S1->S2->SCALE; both are ignored while busy; ready holds in DONE.
  fft_state_e state_q, state_d;
  logic       load;

  logic [W-1:0]        in_re [8], in_im [8];
  logic signed [GW-1:0] din_re_q [8], din_im_q [8];
  logic signed [GW-1:0] s1_re_q [8], s1_im_q [8];
  logic signed [GW-1:0] s2_re_q [8], s2_im_q [8];
  logic [W-1:0]        out_re_q [8], out_im_q [8];

  logic signed [GW-1:0] din_re_d [8], din_im_d [8];
  logic signed [GW-1:0] s2_re_d [8], s2_im_d [8];
  logic [W-1:0]        out_re_d [8], out_im_d [8];
  logic signed [GW-1:0] ev_re [4], ev_im [4], od_re [4], od_im [4];
  logic signed [GW-1:0] e_re [4], e_im [4], o_re [4], o_im [4];

  assign in_re = '{in0_real, in1_real, in2_real, in3_real, in4_real, in5_real, in6_real, in7_real};
  assign in_im = '{in0_imag, in1_imag, in2_imag, in3_imag, in4_imag, in5_imag, in6_imag, in7_imag};

  assign {out0_real, out1_real, out2_real, out3_real} = {out_re_q[0], out_re_q[1], out_re_q[2], out_re_q[3]};
  assign {out4_real, out5_real, out6_real, out7_real} = {out_re_q[4], out_re_q[5], out_re_q[6], out_re_q[7]};
  assign {out0_imag, out1_imag, out2_imag, out3_imag} = {out_im_q[0], out_im_q[1], out_im_q[2], out_im_q[3]};
  assign {out4_imag, out5_imag, out6_imag, out7_imag} = {out_im_q[4], out_im_q[5], out_im_q[6], out_im_q[7]};

  assign ready     = (state_q == DONE);
  assign busy      = (state_q == S1) || (state_q == S2) || (state_q == SCALE);
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (write) load = 1'b1;
        else if (start) state_d = S1;
      end
      S1:    state_d = S2;
      S2:    state_d = SCALE;
      SCALE: state_d = DONE;
      DONE: begin
        if (write) begin
          load    = 1'b1;
          state_d = IDLE;
        end else if (start) begin
          state_d = S1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  function automatic logic signed [31:0] div8(input logic signed [31:0] v);
`ifdef IFFT_ROUND_EN
    div8 = (v + 32'sd4) >>> 3;
`else
    div8 = v >>> 3;
`endif
  endfunction

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      din_re_d[k] = GW'(sm2tc(32'(in_re[k]), W));
      din_im_d[k] = GW'(sm2tc(32'(in_im[k]), W));
      out_re_d[k] = W'(tc2sm(div8(32'(s2_re_q[k])), W));
      out_im_d[k] = W'(tc2sm(div8(32'(s2_im_q[k])), W));
    end
    for (int k = 0; k < 4; k++) begin
      ev_re[k] = din_re_q[2*k];
      ev_im[k] = din_im_q[2*k];
      od_re[k] = din_re_q[2*k+1];
      od_im[k] = din_im_q[2*k+1];
    end
    // Butterfly: x[n] = E[n] + W8^-n O[n], x[n+4] = E[n] - W8^-n O[n].
    for (int n = 0; n < 4; n++) begin
      s2_re_d[n]   = GW'(32'(s1_re_q[n]) + tw_re(32'(s1_re_q[n+4]), 32'(s1_im_q[n+4]), n));
      s2_im_d[n]   = GW'(32'(s1_im_q[n]) + tw_im(32'(s1_re_q[n+4]), 32'(s1_im_q[n+4]), n));
      s2_re_d[n+4] = GW'(32'(s1_re_q[n]) - tw_re(32'(s1_re_q[n+4]), 32'(s1_im_q[n+4]), n));
      s2_im_d[n+4] = GW'(32'(s1_im_q[n]) - tw_im(32'(s1_re_q[n+4]), 32'(s1_im_q[n+4]), n));
    end
  end

  idft4_core #(.GW(GW)) u_even (.a_re_i(ev_re), .a_im_i(ev_im), .y_re_o(e_re), .y_im_o(e_im));
  idft4_core #(.GW(GW)) u_odd  (.a_re_i(od_re), .a_im_i(od_im), .y_re_o(o_re), .y_im_o(o_im));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      din_re_q <= '{default: '0};
      din_im_q <= '{default: '0};
      s1_re_q  <= '{default: '0};
      s1_im_q  <= '{default: '0};
      s2_re_q  <= '{default: '0};
      s2_im_q  <= '{default: '0};
      out_re_q <= '{default: '0};
      out_im_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      if (load) begin
        din_re_q <= din_re_d;
        din_im_q <= din_im_d;
      end
      if (state_q == S1) begin
        for (int k = 0; k < 4; k++) begin
          s1_re_q[k]   <= e_re[k];
          s1_im_q[k]   <= e_im[k];
          s1_re_q[k+4] <= o_re[k];
          s1_im_q[k+4] <= o_im[k];
        end
      end
      if (state_q == S2) begin
        s2_re_q <= s2_re_d;
        s2_im_q <= s2_im_d;
      end
      if (state_q == SCALE) begin
        out_re_q <= out_re_d;
        out_im_q <= out_im_d;
      end
    end
  end

endmodule

// File: tb/tb_eight_point_ifft.sv
// tb_eight_point_ifft: directed-vector bench for eight_point_ifft (honours IFFT_ROUND_EN).
module tb_eight_point_ifft;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, write, start;
  logic [W-1:0] in_re [8], in_im [8];
  logic [W-1:0] out_re [8], out_im [8];
  logic         ready, busy;
  logic [2:0]   dbg_state;
  logic [W-1:0] exp_re [8], exp_im [8];
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  eight_point_ifft #(.W(W)) dut (
    .CLK(clk), .RST(rst), .write(write), .start(start),
    .in0_real(in_re[0]), .in1_real(in_re[1]), .in2_real(in_re[2]), .in3_real(in_re[3]),
    .in4_real(in_re[4]), .in5_real(in_re[5]), .in6_real(in_re[6]), .in7_real(in_re[7]),
    .in0_imag(in_im[0]), .in1_imag(in_im[1]), .in2_imag(in_im[2]), .in3_imag(in_im[3]),
    .in4_imag(in_im[4]), .in5_imag(in_im[5]), .in6_imag(in_im[6]), .in7_imag(in_im[7]),
    .out0_real(out_re[0]), .out1_real(out_re[1]), .out2_real(out_re[2]), .out3_real(out_re[3]),
    .out4_real(out_re[4]), .out5_real(out_re[5]), .out6_real(out_re[6]), .out7_real(out_re[7]),
    .out0_imag(out_im[0]), .out1_imag(out_im[1]), .out2_imag(out_im[2]), .out3_imag(out_im[3]),
    .out4_imag(out_im[4]), .out5_imag(out_im[5]), .out6_imag(out_im[6]), .out7_imag(out_im[7]),
    .ready(ready), .busy(busy), .dbg_state(dbg_state)
  );

  function automatic logic [W-1:0] sm(input int v);
    logic [W-1:0] r;
    r = W'((v < 0) ? -v : v);
    if (v < 0) r[W-1] = 1'b1;
    return r;
  endfunction

  task automatic clear_inputs();
    for (int k = 0; k < 8; k++) begin
      in_re[k] = '0;
      in_im[k] = '0;
    end
  endtask

  task automatic set_exp(input int re [8], input int im [8]);
    for (int k = 0; k < 8; k++) begin
      exp_re[k] = sm(re[k]);
      exp_im[k] = sm(im[k]);
    end
  endtask

  task automatic do_write();
    @(negedge clk); write = 1'b1;
    @(negedge clk); write = 1'b0;
  endtask

  // Returns the number of edges after the start edge until ready is seen (10 = timeout).
  task automatic run_start(output int lat);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (ready !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; write = 1'b0; start = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset ready: got %b, expected 0", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b, expected 0", busy); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_err++; $display("FAIL reset state: got %0d, expected 0", dbg_state); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (out_re[k] !== '0 || out_im[k] !== '0) begin
        n_err++; $display("FAIL reset x%0d: got %h/%h, expected 0/0", k, out_re[k], out_im[k]);
      end
    end
  endtask

  task automatic test_impulse();
    clear_inputs();
    in_re[0] = sm(8);
    do_write();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || ready !== 1'b0) begin n_err++; $display("FAIL impulse edge+0: busy/ready %b%b, expected 10", busy, ready); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || ready !== 1'b0) begin n_err++; $display("FAIL impulse edge+1: busy/ready %b%b, expected 10", busy, ready); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || ready !== 1'b0) begin n_err++; $display("FAIL impulse edge+2: busy/ready %b%b, expected 10", busy, ready); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || ready !== 1'b1) begin n_err++; $display("FAIL impulse edge+3: busy/ready %b%b, expected 01", busy, ready); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (out_re[k] !== sm(1) || out_im[k] !== sm(0)) begin
        n_err++; $display("FAIL impulse x%0d: got %h/%h, expected 0001/0000", k, out_re[k], out_im[k]);
      end
    end
  endtask

  task automatic test_flat();
    int lat;
    clear_inputs();
    for (int k = 0; k < 8; k++) in_re[k] = sm(8);
    do_write();
    run_start(lat);
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL flat latency: got %0d, expected 3", lat); end
    set_exp('{8, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (out_re[k] !== exp_re[k] || out_im[k] !== exp_im[k]) begin
        n_err++; $display("FAIL flat x%0d: got %h/%h, expected %h/%h", k, out_re[k], out_im[k], exp_re[k], exp_im[k]);
      end
    end
  endtask

  task automatic load_tone();
    clear_inputs();
    in_re[1] = sm(8000);
    do_write();
  endtask

  task automatic set_tone_exp();
    set_exp('{1000, 707, 0, -707, -1000, -707, 0, 707}, '{0, 707, 1000, 707, 0, -707, -1000, -707});
  endtask

  task automatic test_tone();
    int lat;
    load_tone();
    run_start(lat);
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL tone latency: got %0d, expected 3", lat); end
    set_tone_exp();
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (out_re[k] !== exp_re[k] || out_im[k] !== exp_im[k]) begin
        n_err++; $display("FAIL tone x%0d: got %h/%h, expected %h/%h", k, out_re[k], out_im[k], exp_re[k], exp_im[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_start(lat);
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL recompute latency: got %0d, expected 3", lat); end
    set_tone_exp();
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (out_re[k] !== exp_re[k] || out_im[k] !== exp_im[k]) begin
        n_err++; $display("FAIL recompute x%0d: got %h/%h, expected %h/%h", k, out_re[k], out_im[k], exp_re[k], exp_im[k]);
      end
    end
  endtask

  task automatic test_write_while_busy();
    int lat;
    load_tone();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    clear_inputs();
    in_re[0] = sm(8);
    write = 1'b1;
    @(negedge clk); write = 1'b0;
    lat = 0;
    while (ready !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL busy-write latency: got %0d, expected 1", lat); end
    set_tone_exp();
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (out_re[k] !== exp_re[k] || out_im[k] !== exp_im[k]) begin
        n_err++; $display("FAIL busy-write x%0d: got %h/%h, expected %h/%h", k, out_re[k], out_im[k], exp_re[k], exp_im[k]);
      end
    end
    run_start(lat);
    n_cmp++; if (out_re[0] !== sm(1000)) begin n_err++; $display("FAIL busy-write held data x0: got %h, expected %h", out_re[0], sm(1000)); end
  endtask

  task automatic test_write_start_together();
    int lat;
    clear_inputs();
    in_re[0] = sm(8);
    @(negedge clk); write = 1'b1; start = 1'b1;
    @(negedge clk); write = 1'b0; start = 1'b0;
    n_cmp++; if (ready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL write+start: busy/ready %b%b, expected 00", busy, ready); end
    repeat (2) @(negedge clk);
    n_cmp++; if (ready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL write+start later: busy/ready %b%b, expected 00", busy, ready); end
    run_start(lat);
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (out_re[k] !== sm(1) || out_im[k] !== sm(0)) begin
        n_err++; $display("FAIL write+start x%0d: got %h/%h, expected 0001/0000", k, out_re[k], out_im[k]);
      end
    end
  endtask

  task automatic test_mixed();
    int lat;
    clear_inputs();
    in_im[2] = sm(800);
    in_re[4] = sm(-80);
    do_write();
    run_start(lat);
    set_exp('{-10, -90, -10, 110, -10, -90, -10, 110}, '{100, 0, -100, 0, 100, 0, -100, 0});
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (out_re[k] !== exp_re[k] || out_im[k] !== exp_im[k]) begin
        n_err++; $display("FAIL mixed x%0d: got %h/%h, expected %h/%h", k, out_re[k], out_im[k], exp_re[k], exp_im[k]);
      end
    end
  endtask

  task automatic test_rounding();
    int lat;
    logic [W-1:0] exp_pos, exp_neg;
`ifdef IFFT_ROUND_EN
    exp_pos = 16'h0001; exp_neg = 16'h0000;
`else
    exp_pos = 16'h0000; exp_neg = 16'h8001;
`endif
    clear_inputs();
    in_re[0] = sm(4);
    do_write();
    run_start(lat);
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (out_re[k] !== exp_pos || out_im[k] !== 16'h0000) begin
        n_err++; $display("FAIL round +4 x%0d: got %h/%h, expected %h/0000", k, out_re[k], out_im[k], exp_pos);
      end
    end
    in_re[0] = sm(-4);
    do_write();
    run_start(lat);
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (out_re[k] !== exp_neg || out_im[k] !== 16'h0000) begin
        n_err++; $display("FAIL round -4 x%0d: got %h/%h, expected %h/0000", k, out_re[k], out_im[k], exp_neg);
      end
    end
  endtask

  task automatic test_reset_mid();
    load_tone();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_cmp++; if (dbg_state !== 3'd1) begin n_err++; $display("FAIL reset-mid in S1: state %0d, expected 1", dbg_state); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_cmp++; if (busy !== 1'b0 || ready !== 1'b0) begin n_err++; $display("FAIL reset-mid: busy/ready %b%b, expected 00", busy, ready); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (out_re[k] !== '0 || out_im[k] !== '0) begin
        n_err++; $display("FAIL reset-mid x%0d: got %h/%h, expected 0/0", k, out_re[k], out_im[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_flat();
    test_tone();
    test_back_to_back();
    test_write_while_busy();
    test_write_start_together();
    test_mixed();
    test_rounding();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eight_point_ifft.md
# eight_point_ifft

Eight-point radix-2/4 inverse FFT that consumes the sign-magnitude complex bins produced by the forward eight-point FFT and returns time-domain samples, scaled by 1/8, in the same sign-magnitude format. It sits downstream of the forward FFT on the return path. It reuses the same write/start/ready handshake so both ends are driven identically. Computation is a registered three-stage sequence under a small FSM.

## Interface
- `W`, default 16: sample width per real/imag component, sign-magnitude.
- `GW`, default `W+3`: internal two's-complement width covering 8x growth.
- `CLK` in 1: sole clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `write` in 1: load all 16 input words this cycle.
- `start` in 1: begin transform on loaded data.
- `in0_real`..`in7_real`, `in0_imag`..`in7_imag` in `W` each: bins X[0..7], sign-magnitude.
- `out0_real`..`out7_real`, `out0_imag`..`out7_imag` out `W` each: samples x[0..7], sign-magnitude.
- `ready` out 1: result valid, held.
- `busy` out 1: transform in progress.

## Operation
- FSM states and transitions:
  - IDLE: on `start`, go to S1.
  - S1 -> S2 -> SCALE, one cycle each.
  - SCALE: go to DONE.
  - DONE: stays until `write` or `start`.
- Load path:
  - `write` in IDLE or DONE converts inputs sign-magnitude -> two's complement, sign-extends to `GW`, and registers them.
  - `write` clears `ready` and returns to IDLE.
- S1: two 4-point IDFTs, one on the even bins X0,2,4,6 and one on the odd bins X1,3,5,7. Uses the +j kernel: k=1 term is a+jb... i.e. out1 = in0 − j·in1·(−1) convention, which equals conj of the forward kernel. Results are registered.
- S2: combine E[k] ± W8^−k·O[k] with conjugate twiddles:
  - W8^0 = 1
  - W8^−1 = (1+j)c
  - W8^−2 = j
  - W8^−3 = (−1+j)c
  - c = 0.70703, computed by shift-add: x>>>1 + x>>>2 − x>>>4 + x>>>5 − x>>>6 + x>>>7 − x>>>8, all arithmetic shifts.
- SCALE: arithmetic shift right by 3, then convert two's complement -> sign-magnitude. Negative zero is never emitted: a zero magnitude always has sign 0. Results are registered onto the outputs.
- Range: after scaling, |value| ≤ 2^(W−1)−1, so no saturation is required.
- Outputs hold their last value until the next SCALE.

## Timing
- Reset: all outputs 0, `ready`=0, `busy`=0, FSM in IDLE, input registers 0.
- Latency: `start` sampled at edge N -> outputs and `ready` valid after edge N+3. `busy` is high during S1, S2 and SCALE.
- `write` and `start` in the same cycle: `write` wins and `start` is ignored.
- `write` or `start` while busy: ignored. The transform in flight is unaffected.
- `start` in DONE without `write`: recomputes on the held inputs. `ready` drops for 3 cycles, then reasserts.
- `RST` mid-transform: IDLE on the next edge, outputs 0, `ready`=0.

## Configuration
- `IFFT_ROUND_EN`:
  - Defined: SCALE adds 4 before >>>3, i.e. round half toward +inf.
  - Undefined: plain >>>3, truncation toward −inf.
  - Latency is the same either way.

## Structure
- Shared package `fft_pkg`:
  - `W` and `GW` defaults.
  - FSM state enum (IDLE, S1, S2, SCALE, DONE).
  - Twiddle shift-add function `mul_c707`.
  - `sm2tc` and `tc2sm` conversion functions.
  - The forward FFT migrates to the same package.
- Sub-module `idft4_core`: combinational 4-point IDFT on `GW`-wide signed operands. It is instantiated twice in S1.

## Test plan
- Impulse: X0 = 8+0j, other bins 0, `write` then `start` -> all x[n] = 1+0j; `ready` rises exactly 3 edges after `start`.
- Flat spectrum: all X[k] = 8+0j -> x0 = 8+0j, x1..x7 = 0 with sign bit 0.
- Single tone: X1 = 8000+0j, rest 0:
  - x0 = 1000
  - x1 = 707+707j
  - x2 = 0+1000j
  - x4 = −1000 (0x83E8)
  - x6 = 0−1000j
- Rounding: X0 = 4+0j, rest 0 -> x[n] = 0 without `IFFT_ROUND_EN` and 1 with it. Also X0 = −4: −1 (0x8001) without, 0 (0x0000) with.
- Handshake:
  - `write` pulsed during S2 does not alter the result.
  - `write` and `start` together load the data only; `ready` stays 0 and `busy` stays 0.
- Reset and round-trip:
  - Assert `RST` in S1 -> next edge `busy`=0, `ready`=0, outputs 0.
  - Forward-FFT output for random inputs fed back through the IFFT reproduces the inputs within ±2 LSB.
